// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and instruction memory.
interface ifetch_unit_if #(
  parameter int ADDR_W = 14
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack bus, resolves next-PC.
// Optional perf counters (stall_cycles, retired) are built when IFETCH_PERF_EN is defined.
module ifetch_unit #(
  parameter int          ADDR_W   = 14,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clock,
  input  logic         reset,
  ifetch_unit_if.master imem,
  output logic [31:0]  Instruction,
  output logic         instr_valid,
  input  logic         advance,
  input  logic         Branch,
  input  logic         nBranch,
  input  logic         Zero,
  input  logic         Jmp,
  input  logic         Jal,
  input  logic         Jr,
  input  logic [31:0]  Read_data_1,
  input  logic [31:0]  Imme_extend,
  output logic [31:0]  PC,
  output logic [31:0]  opcplus4,
  output logic         fault,
  output logic [31:0]  stall_cycles,
  output logic [31:0]  retired
);

  typedef enum logic [1:0] {S_REQ, S_READY, S_FAULT} state_t;

  state_t      state, state_nxt;
  logic        fetch_done;
  logic        pc_take;
  logic        fault_take;
  logic        br_taken;
  logic        jr_misaligned;
  logic [31:0] next_pc;

  // Branch offset is a signed word displacement; the sum wraps at 32 bits.
  function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                input logic signed [31:0] imm);
    logic signed [31:0] offs;
    offs = imm <<< 2;
    return base + offs;
  endfunction

  assign imem.imem_req  = (state == S_REQ) & ~reset;
  assign imem.imem_addr = PC[ADDR_W+1:2];

  assign br_taken      = (Branch & Zero) | (nBranch & ~Zero);
  assign jr_misaligned = Jr & (Read_data_1[1:0] != 2'b00);

  always_comb begin
    next_pc = opcplus4;
    if (Jr)
      next_pc = Read_data_1;
    else if (Jmp | Jal)
      next_pc = {opcplus4[31:28], Instruction[25:0], 2'b00};
    else if (br_taken)
      next_pc = branch_target(opcplus4, Imme_extend);
  end

  always_comb begin
    state_nxt  = state;
    fetch_done = 1'b0;
    pc_take    = 1'b0;
    fault_take = 1'b0;
    case (state)
      S_REQ: begin
        if (imem.imem_ack) begin
          fetch_done = 1'b1;
          state_nxt  = S_READY;
        end
      end
      S_READY: begin
        if (advance) begin
          if (jr_misaligned) begin
            fault_take = 1'b1;
            state_nxt  = S_FAULT;
          end else begin
            pc_take   = 1'b1;
            state_nxt = S_REQ;
          end
        end
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_REQ;
      PC          <= RESET_PC;
      Instruction <= 32'd0;
      opcplus4    <= 32'd0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fetch_done) begin
        Instruction <= imem.imem_rdata;
        opcplus4    <= PC + 32'd4;
        instr_valid <= 1'b1;
      end
      if (pc_take) begin
        PC          <= next_pc;
        instr_valid <= 1'b0;
      end
      if (fault_take) begin
        instr_valid <= 1'b0;
        fault       <= 1'b1;
      end
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] retired_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q   <= 32'd0;
      retired_q <= 32'd0;
    end else begin
      if (state == S_REQ)
        stall_q <= stall_q + 32'd1;
      if ((state == S_READY) && advance)
        retired_q <= retired_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign retired      = retired_q;
`else
  assign stall_cycles = 32'd0;
  assign retired      = 32'd0;
`endif

endmodule
